// File: rtl/hs_rx_pkt_parser_pkg.sv
// Shared constants for the HS receive packet parser: state encoding, header
// byte indices, CRC16 parameters and the byte-wide CRC step.
package hs_rx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_HDR     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_FOOTER  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] HDR_DI     = 2'd0;
  localparam logic [1:0] HDR_WC_LSB = 2'd1;
  localparam logic [1:0] HDR_WC_MSB = 2'd2;
  localparam logic [1:0] HDR_ECC    = 2'd3;

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  localparam logic [5:0] SHORT_DT_MAX_DEF = 6'h0F;

  // Reflected CRC16, data consumed LSB-first.
  function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn,
                                            input logic [7:0]  dataIn);
    logic [15:0] c;
    c = crcIn;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ dataIn[i]) c = (c >> 1) ^ CRC_POLY;
      else                  c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hs_rx_pkt_parser_if.sv
// Byte-side PPI inputs and link-layer packet outputs of the HS receive parser.
interface hs_rx_pkt_parser_if;
  logic        RxActiveHS;
  logic        RxSyncHS;
  logic        RxValidHS;
  logic [7:0]  RxDataHS;
  logic        PktHdrValid;
  logic [1:0]  PktVC;
  logic [5:0]  PktDataType;
  logic [15:0] PktWordCount;
  logic [7:0]  PktEcc;
  logic        PktShort;
  logic [7:0]  PayloadData;
  logic        PayloadValid;
  logic        PayloadLast;
  logic        PktDone;
  logic        PktAbort;
  logic        CrcErr;

  modport master (
    output RxActiveHS, RxSyncHS, RxValidHS, RxDataHS,
    input  PktHdrValid, PktVC, PktDataType, PktWordCount, PktEcc, PktShort,
           PayloadData, PayloadValid, PayloadLast, PktDone, PktAbort, CrcErr
  );

  modport slave (
    input  RxActiveHS, RxSyncHS, RxValidHS, RxDataHS,
    output PktHdrValid, PktVC, PktDataType, PktWordCount, PktEcc, PktShort,
           PayloadData, PayloadValid, PayloadLast, PktDone, PktAbort, CrcErr
  );
endinterface

// File: rtl/hs_rx_pkt_parser_crc16.sv
// Byte-wide CRC16 accumulator with synchronous clear and enable.
module hs_rx_crc16
  import hs_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)    crc <= CRC_SEED;
    else if (clr) crc <= CRC_SEED;
    else if (en)  crc <= crc16Byte(crc, data);
  end

endmodule

// File: rtl/hs_rx_pkt_parser.sv
// CSI-2 packet parser on the HS receive byte stream (RxByteClkHS domain).
// Define HS_RX_CRC_CHECK_EN to check the payload CRC16 against the footer.
module hs_rx_pkt_parser
  import hs_rx_pkg::*;
#(
  parameter int unsigned WC_W         = 16,
  parameter logic [5:0]  SHORT_DT_MAX = SHORT_DT_MAX_DEF
) (
  input logic              RxByteClkHS,
  input logic              RST,
  hs_rx_pkt_parser_if.slave bus
);

  logic [2:0]      state;
  logic [1:0]      hdrIdx;
  logic [7:0]      diReg;
  logic [15:0]     wcReg;
  logic [WC_W-1:0] remaining;
  logic            footHi;
  logic            accept;
  logic            inBurst;
  logic            isShort;

  assign accept  = bus.RxValidHS & bus.RxActiveHS;
  assign inBurst = (state == ST_ARMED) || (state == ST_HDR) ||
                   (state == ST_PAYLOAD) || (state == ST_FOOTER);
  assign isShort = (diReg[5:0] <= SHORT_DT_MAX);

  always_ff @(posedge RxByteClkHS or negedge RST) begin
    if (!RST) begin
      state            <= ST_IDLE;
      hdrIdx           <= HDR_DI;
      diReg            <= '0;
      wcReg            <= '0;
      remaining        <= '0;
      footHi           <= 1'b0;
      bus.PktHdrValid  <= 1'b0;
      bus.PktVC        <= '0;
      bus.PktDataType  <= '0;
      bus.PktWordCount <= '0;
      bus.PktEcc       <= '0;
      bus.PktShort     <= 1'b0;
      bus.PayloadData  <= '0;
      bus.PayloadValid <= 1'b0;
      bus.PayloadLast  <= 1'b0;
      bus.PktDone      <= 1'b0;
      bus.PktAbort     <= 1'b0;
    end else begin
      bus.PktHdrValid  <= 1'b0;
      bus.PayloadValid <= 1'b0;
      bus.PayloadLast  <= 1'b0;
      bus.PktDone      <= 1'b0;
      bus.PktAbort     <= 1'b0;
      if (inBurst && !bus.RxActiveHS) begin
        bus.PktAbort <= 1'b1;
        state        <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.RxSyncHS && bus.RxActiveHS) begin
              if (bus.RxValidHS) begin
                diReg  <= bus.RxDataHS;
                hdrIdx <= HDR_WC_LSB;
                state  <= ST_HDR;
              end else begin
                state <= ST_ARMED;
              end
            end
          end
          ST_ARMED: begin
            if (accept) begin
              diReg  <= bus.RxDataHS;
              hdrIdx <= HDR_WC_LSB;
              state  <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (accept) begin
              case (hdrIdx)
                HDR_WC_LSB: begin
                  wcReg[7:0] <= bus.RxDataHS;
                  hdrIdx     <= HDR_WC_MSB;
                end
                HDR_WC_MSB: begin
                  wcReg[15:8] <= bus.RxDataHS;
                  hdrIdx      <= HDR_ECC;
                end
                HDR_ECC: begin
                  bus.PktHdrValid  <= 1'b1;
                  bus.PktVC        <= diReg[7:6];
                  bus.PktDataType  <= diReg[5:0];
                  bus.PktWordCount <= wcReg;
                  bus.PktEcc       <= bus.RxDataHS;
                  bus.PktShort     <= isShort;
                  footHi           <= 1'b0;
                  if (isShort) begin
                    bus.PktDone <= 1'b1;
                    state       <= ST_DONE;
                  end else if (wcReg == '0) begin
                    state <= ST_FOOTER;
                  end else begin
                    remaining <= WC_W'(wcReg);
                    state     <= ST_PAYLOAD;
                  end
                end
                default: hdrIdx <= HDR_WC_LSB;
              endcase
            end
          end
          ST_PAYLOAD: begin
            if (accept) begin
              bus.PayloadData  <= bus.RxDataHS;
              bus.PayloadValid <= 1'b1;
              remaining        <= remaining - WC_W'(1);
              if (remaining == WC_W'(1)) begin
                bus.PayloadLast <= 1'b1;
                state           <= ST_FOOTER;
              end
            end
          end
          ST_FOOTER: begin
            if (accept) begin
              if (!footHi) begin
                footHi <= 1'b1;
              end else begin
                bus.PktDone <= 1'b1;
                state       <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (!bus.RxActiveHS) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef HS_RX_CRC_CHECK_EN
  logic        diAcc;
  logic        payAcc;
  logic [15:0] crcVal;
  logic [7:0]  footLsb;

  // CRC restarts on every DI byte, so WC=0 packets compare against the seed.
  assign diAcc  = accept && ((state == ST_ARMED) ||
                             (state == ST_IDLE && bus.RxSyncHS));
  assign payAcc = accept && (state == ST_PAYLOAD);

  hs_rx_crc16 uCrc (
    .clk  (RxByteClkHS),
    .rstN (RST),
    .clr  (diAcc),
    .en   (payAcc),
    .data (bus.RxDataHS),
    .crc  (crcVal)
  );

  always_ff @(posedge RxByteClkHS or negedge RST) begin
    if (!RST) begin
      footLsb    <= '0;
      bus.CrcErr <= 1'b0;
    end else begin
      bus.CrcErr <= 1'b0;
      if (accept && state == ST_FOOTER && bus.RxActiveHS) begin
        if (!footHi) footLsb    <= bus.RxDataHS;
        else         bus.CrcErr <= (crcVal != {bus.RxDataHS, footLsb});
      end
    end
  end
`else
  assign bus.CrcErr = 1'b0;
`endif

endmodule
